// File: rtl/video_sync_detector.sv
// Raster timing detector: measures hsync/vsync geometry every frame and
// asserts lock once LOCK_FRAMES consecutive frames repeat the reference.
module video_sync_detector #(
  parameter int unsigned H_CNT_WIDTH = 12,
  parameter int unsigned V_CNT_WIDTH = 11,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  output logic                   o_locked,
  output logic [H_CNT_WIDTH-1:0] o_h_total,
  output logic [H_CNT_WIDTH-1:0] o_h_sync_len,
  output logic [V_CNT_WIDTH-1:0] o_v_total,
  output logic [V_CNT_WIDTH-1:0] o_v_sync_len,
  output logic [H_CNT_WIDTH-1:0] o_hpos,
  output logic [V_CNT_WIDTH-1:0] o_vpos,
  output logic                   o_frame_strobe,
  output logic                   o_error
);

  localparam int unsigned MATCH_WIDTH = 4;
  localparam logic [H_CNT_WIDTH-1:0] H_ONE  = H_CNT_WIDTH'(1);
  localparam logic [H_CNT_WIDTH-1:0] H_MAX  = '1;
  localparam logic [H_CNT_WIDTH-1:0] H_LAST = H_MAX - H_ONE;
  localparam logic [V_CNT_WIDTH-1:0] V_ONE  = V_CNT_WIDTH'(1);
  localparam logic [V_CNT_WIDTH-1:0] V_MAX  = '1;
  localparam logic [V_CNT_WIDTH-1:0] V_LAST = V_MAX - V_ONE;
  localparam logic [MATCH_WIDTH-1:0] MATCH_ONE  = MATCH_WIDTH'(1);
  localparam logic [MATCH_WIDTH-1:0] MATCH_LOCK = MATCH_WIDTH'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t                  state;
  logic                    hs_prev, vs_prev;
  logic [H_CNT_WIDTH-1:0]  hcnt, h_meas, hs_cnt, hs_meas;
  logic [V_CNT_WIDTH-1:0]  vcnt, vs_cnt, vs_meas;
  logic [H_CNT_WIDTH-1:0]  ref_h, ref_hs;
  logic [V_CNT_WIDTH-1:0]  ref_v, ref_vs;
  logic [MATCH_WIDTH-1:0]  match_cnt;
  logic                    h_valid, h_unstable;

  logic                    h_rise, h_fall, v_rise, v_fall;
  logic                    h_ovf, v_ovf, ovf, frame_good;
  logic [H_CNT_WIDTH-1:0]  h_cap;
  logic [V_CNT_WIDTH-1:0]  v_meas;
  logic [MATCH_WIDTH-1:0]  match_next;

  // Edge detection, current-frame measurement and overflow detection
  always_comb begin
    h_rise     = i_hsync & ~hs_prev;
    h_fall     = ~i_hsync & hs_prev;
    v_rise     = i_vsync & ~vs_prev;
    v_fall     = ~i_vsync & vs_prev;
    h_cap      = hcnt + H_ONE;
    v_meas     = h_rise ? (vcnt + V_ONE) : vcnt;
    h_ovf      = ~h_rise & (hcnt == H_LAST);
    v_ovf      = ~v_rise & h_rise & (vcnt == V_LAST);
    ovf        = h_ovf | v_ovf;
    frame_good = ~h_unstable & (h_meas == ref_h) & (hs_meas == ref_hs) &
                 (v_meas == ref_v) & (vs_meas == ref_vs);
    match_next = match_cnt + MATCH_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= SEARCH;
      hs_prev        <= 1'b0;
      vs_prev        <= 1'b0;
      hcnt           <= '0;
      h_meas         <= '0;
      hs_cnt         <= '0;
      hs_meas        <= '0;
      vcnt           <= '0;
      vs_cnt         <= '0;
      vs_meas        <= '0;
      ref_h          <= '0;
      ref_hs         <= '0;
      ref_v          <= '0;
      ref_vs         <= '0;
      match_cnt      <= '0;
      h_valid        <= 1'b0;
      h_unstable     <= 1'b0;
      o_locked       <= 1'b0;
      o_h_total      <= '0;
      o_h_sync_len   <= '0;
      o_v_total      <= '0;
      o_v_sync_len   <= '0;
      o_frame_strobe <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      hs_prev        <= i_hsync;
      vs_prev        <= i_vsync;
      o_frame_strobe <= 1'b0;
      o_error        <= 1'b0;

      // Horizontal line length, stability and sync width
      if (h_rise) begin
        hcnt    <= '0;
        h_meas  <= h_cap;
        h_valid <= 1'b1;
        if (h_valid && (h_cap != h_meas)) h_unstable <= 1'b1;
      end else if (hcnt != H_MAX) begin
        hcnt <= h_cap;
      end

      if (h_rise)                           hs_cnt <= H_ONE;
      else if (i_hsync && hs_cnt != H_MAX)  hs_cnt <= hs_cnt + H_ONE;
      if (h_fall)                           hs_meas <= hs_cnt;

      // Vertical line count and sync width in lines
      if (v_rise)                           vcnt <= '0;
      else if (h_rise && vcnt != V_MAX)     vcnt <= vcnt + V_ONE;

      if (v_rise)                           vs_cnt <= h_rise ? V_ONE : '0;
      else if (i_vsync && h_rise && vs_cnt != V_MAX) vs_cnt <= vs_cnt + V_ONE;
      if (v_fall)                           vs_meas <= vs_cnt;

      // Frame evaluation; a counter overflow abandons it and restarts the search
      if (ovf) begin
        o_error   <= 1'b1;
        o_locked  <= 1'b0;
        match_cnt <= '0;
        state     <= SEARCH;
      end else if (v_rise) begin
        h_unstable <= 1'b0;
        case (state)
          SEARCH: begin
            h_valid <= 1'b0;
            state   <= MEASURE;
          end
          MEASURE: begin
            o_frame_strobe <= 1'b1;
            {ref_h, ref_hs, ref_v, ref_vs} <= {h_meas, hs_meas, v_meas, vs_meas};
            match_cnt <= '0;
            state     <= VERIFY;
          end
          VERIFY: begin
            o_frame_strobe <= 1'b1;
            if (frame_good) begin
              match_cnt <= match_next;
              if (match_next == MATCH_LOCK) begin
                state        <= LOCKED;
                o_locked     <= 1'b1;
                o_h_total    <= ref_h;
                o_h_sync_len <= ref_hs;
                o_v_total    <= ref_v;
                o_v_sync_len <= ref_vs;
              end
            end else begin
              {ref_h, ref_hs, ref_v, ref_vs} <= {h_meas, hs_meas, v_meas, vs_meas};
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            o_frame_strobe <= 1'b1;
            if (!frame_good) begin
              {ref_h, ref_hs, ref_v, ref_vs} <= {h_meas, hs_meas, v_meas, vs_meas};
              match_cnt <= '0;
              o_locked  <= 1'b0;
              state     <= VERIFY;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign o_hpos = hcnt;
  assign o_vpos = vcnt;

endmodule

// File: tb/tb_video_sync_detector.sv
// Directed bench for video_sync_detector using a reduced raster
// (64-clock lines, 8-clock hsync, 20 lines, 2-line vsync) to keep frames short.
module tb_video_sync_detector;

  localparam int H_TOT  = 64;
  localparam int H_SYNC = 8;
  localparam int V_TOT  = 20;
  localparam int V_SYNC = 2;

  logic        i_clk, i_rst_n, i_hsync, i_vsync;
  logic        o_locked, o_frame_strobe, o_error;
  logic [11:0] o_h_total, o_h_sync_len, o_hpos;
  logic [10:0] o_v_total, o_v_sync_len, o_vpos;

  int checks;
  int errors;
  int err_pulses;

  video_sync_detector dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_hsync        (i_hsync),
    .i_vsync        (i_vsync),
    .o_locked       (o_locked),
    .o_h_total      (o_h_total),
    .o_h_sync_len   (o_h_sync_len),
    .o_v_total      (o_v_total),
    .o_v_sync_len   (o_v_sync_len),
    .o_hpos         (o_hpos),
    .o_vpos         (o_vpos),
    .o_frame_strobe (o_frame_strobe),
    .o_error        (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_error === 1'b1) err_pulses++;
  endtask

  // One frame starting at the hsync rise of line 0; vsync rises voff clocks later.
  task automatic drive_frame(input int nlines, input int odd_line, input int odd_len,
                             input int voff, output logic lk_before, output logic lk_after,
                             output logic strb_after, output int hpos_after,
                             output int vpos_after, output int strobes);
    int f;
    int len;
    f = 0; strobes = 0; lk_before = 1'b0; lk_after = 1'b0; strb_after = 1'b0;
    hpos_after = -1; vpos_after = -1;
    for (int l = 0; l < nlines; l++) begin
      len = (l == odd_line) ? odd_len : H_TOT;
      for (int x = 0; x < len; x++) begin
        i_hsync = (x < H_SYNC);
        i_vsync = (f >= voff) && (f < voff + V_SYNC * H_TOT);
        if (f == voff) lk_before = o_locked;
        tick();
        if (o_frame_strobe === 1'b1) strobes++;
        if (f == voff) begin
          lk_after   = o_locked;
          strb_after = o_frame_strobe;
          hpos_after = int'(o_hpos);
          vpos_after = int'(o_vpos);
        end
        f++;
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_locked, o_frame_strobe, o_error} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {o_locked, o_frame_strobe, o_error});
    end
    checks++;
    if ({o_h_total, o_h_sync_len, o_v_total, o_v_sync_len} !== 46'd0) begin
      errors++; $display("FAIL reset_totals: got %0d/%0d/%0d/%0d expected 0/0/0/0",
                         o_h_total, o_h_sync_len, o_v_total, o_v_sync_len);
    end
    checks++;
    if ({o_hpos, o_vpos} !== 23'd0) begin
      errors++; $display("FAIL reset_pos: got %0d/%0d expected 0/0", o_hpos, o_vpos);
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    logic lb, la, sa;
    int hp, vp, st;
    err_pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      drive_frame(V_TOT, -1, 0, 0, lb, la, sa, hp, vp, st);
      checks++;
      if (la !== 1'(k == 4)) begin
        errors++; $display("FAIL lock_vrise%0d: got %b expected %b", k, la, k == 4);
      end
      checks++;
      if (st != ((k >= 2) ? 1 : 0)) begin
        errors++; $display("FAIL lock_strobes%0d: got %0d expected %0d", k, st, (k >= 2) ? 1 : 0);
      end
      if (k == 1) begin
        checks++;
        if (hp != 0 || vp != 0) begin
          errors++; $display("FAIL lock_pos_at_vrise: got %0d/%0d expected 0/0", hp, vp);
        end
      end
      if (k == 4) begin
        checks++;
        if (lb !== 1'b0) begin
          errors++; $display("FAIL lock_before_4th: got %b expected 0", lb);
        end
      end
    end
    checks++;
    if (o_h_total !== 12'd64 || o_h_sync_len !== 12'd8 || o_v_total !== 11'd20 || o_v_sync_len !== 11'd2) begin
      errors++; $display("FAIL lock_totals: got %0d/%0d/%0d/%0d expected 64/8/20/2",
                         o_h_total, o_h_sync_len, o_v_total, o_v_sync_len);
    end
    checks++;
    if (err_pulses != 0) begin
      errors++; $display("FAIL lock_no_error: got %0d pulses expected 0", err_pulses);
    end
  endtask

  task automatic test_frame_mismatch();
    logic lb, la, sa;
    int hp, vp, st;
    drive_frame(V_TOT + 1, -1, 0, 0, lb, la, sa, hp, vp, st);
    checks++;
    if (la !== 1'b1) begin
      errors++; $display("FAIL mismatch_long_frame_start: got %b expected 1", la);
    end
    for (int k = 1; k <= 4; k++) begin
      drive_frame(V_TOT, -1, 0, 0, lb, la, sa, hp, vp, st);
      checks++;
      if (la !== 1'(k == 4)) begin
        errors++; $display("FAIL mismatch_vrise%0d: got %b expected %b", k, la, k == 4);
      end
      if (k == 1) begin
        checks++;
        if (lb !== 1'b1 || sa !== 1'b1) begin
          errors++; $display("FAIL mismatch_drop: got locked_before=%b strobe=%b expected 1/1", lb, sa);
        end
        checks++;
        if (o_v_total !== 11'd20 || o_h_total !== 12'd64) begin
          errors++; $display("FAIL mismatch_held: got %0d/%0d expected 20/64", o_v_total, o_h_total);
        end
      end
    end
  endtask

  task automatic test_reset_locked();
    logic lb, la, sa;
    int hp, vp, st;
    i_hsync = 1'b0; i_vsync = 1'b0;
    tick();
    i_rst_n = 1'b0;
    tick();
    checks++;
    if ({o_locked, o_frame_strobe, o_error, o_h_total, o_h_sync_len, o_v_total,
         o_v_sync_len, o_hpos, o_vpos} !== 72'd0) begin
      errors++; $display("FAIL reset_locked_outputs: got locked=%b h=%0d hs=%0d v=%0d vs=%0d hpos=%0d vpos=%0d expected all 0",
                         o_locked, o_h_total, o_h_sync_len, o_v_total, o_v_sync_len, o_hpos, o_vpos);
    end
    i_rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive_frame(V_TOT, -1, 0, 0, lb, la, sa, hp, vp, st);
      checks++;
      if (la !== 1'(k == 4)) begin
        errors++; $display("FAIL relock_vrise%0d: got %b expected %b", k, la, k == 4);
      end
    end
  endtask

  task automatic test_overflow();
    logic prev_locked;
    bit   hit;
    int   n;
    hit = 1'b0; n = 0; prev_locked = 1'b0;
    err_pulses = 0;
    i_hsync = 1'b0; i_vsync = 1'b0;
    checks++;
    if (o_locked !== 1'b1) begin
      errors++; $display("FAIL ovf_precondition_locked: got %b expected 1", o_locked);
    end
    while (!hit && n < 5000) begin
      prev_locked = o_locked;
      tick();
      n++;
      if (o_hpos === 12'd4095) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL ovf_timeout: got hpos=%0d expected 4095 within 5000 cycles", o_hpos);
    end else begin
      checks++;
      if (o_error !== 1'b1 || o_locked !== 1'b0 || prev_locked !== 1'b1) begin
        errors++; $display("FAIL ovf_edge: got error=%b locked=%b prev_locked=%b expected 1/0/1",
                           o_error, o_locked, prev_locked);
      end
    end
    repeat (20) tick();
    checks++;
    if (o_hpos !== 12'd4095 || err_pulses != 1 || o_locked !== 1'b0) begin
      errors++; $display("FAIL ovf_saturate: got hpos=%0d pulses=%0d locked=%b expected 4095/1/0",
                         o_hpos, err_pulses, o_locked);
    end
  endtask

  task automatic test_unstable_line();
    logic lb, la, sa;
    int hp, vp, st;
    for (int k = 1; k <= 5; k++) begin
      drive_frame(V_TOT, (k == 2) ? 10 : -1, H_TOT + 1, 0, lb, la, sa, hp, vp, st);
      checks++;
      if (la !== 1'(k == 5)) begin
        errors++; $display("FAIL unstable_vrise%0d: got %b expected %b", k, la, k == 5);
      end
    end
    checks++;
    if (o_h_total !== 12'd64 || o_h_sync_len !== 12'd8 || o_v_total !== 11'd20 || o_v_sync_len !== 11'd2) begin
      errors++; $display("FAIL unstable_totals: got %0d/%0d/%0d/%0d expected 64/8/20/2",
                         o_h_total, o_h_sync_len, o_v_total, o_v_sync_len);
    end
  endtask

  task automatic test_vsync_offset();
    logic lb, la, sa;
    int hp, vp, st;
    i_hsync = 1'b0; i_vsync = 1'b0; i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    err_pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      drive_frame(V_TOT, -1, 0, 10, lb, la, sa, hp, vp, st);
      checks++;
      if (la !== 1'(k == 4)) begin
        errors++; $display("FAIL offset_vrise%0d: got %b expected %b", k, la, k == 4);
      end
      if (k == 2) begin
        checks++;
        if (hp != 10 || vp != 0 || sa !== 1'b1) begin
          errors++; $display("FAIL offset_pos: got hpos=%0d vpos=%0d strobe=%b expected 10/0/1", hp, vp, sa);
        end
      end
    end
    checks++;
    if (o_v_total !== 11'd20 || o_v_sync_len !== 11'd2 || o_h_total !== 12'd64 || err_pulses != 0) begin
      errors++; $display("FAIL offset_totals: got v=%0d vs=%0d h=%0d pulses=%0d expected 20/2/64/0",
                         o_v_total, o_v_sync_len, o_h_total, err_pulses);
    end
  endtask

  initial begin
    checks = 0; errors = 0; err_pulses = 0;
    i_rst_n = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
    test_reset();
    test_lock();
    test_frame_mismatch();
    test_reset_locked();
    test_overflow();
    test_unstable_line();
    test_vsync_offset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
